// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises MOSI frames into RAM command words and shifts RAM read data out on MISO.
// rx_valid rises on the 12th edge after SS_n is sampled low; no backpressure, SS_n high aborts any frame.
module spi_slave_ctrl #(
    parameter int MEM_WIDTH = 8,
    parameter int RX_WIDTH  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [RX_WIDTH-1:0]  rx_data,
    output logic                 rx_valid,
    input  logic [MEM_WIDTH-1:0] tx_data,
    input  logic                 tx_valid
);

    localparam int BIT_W = $clog2(RX_WIDTH + 1);
    localparam int TX_W  = $clog2(MEM_WIDTH);

    localparam logic [BIT_W-1:0] RX_BITS  = BIT_W'(RX_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(RX_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [RX_WIDTH-2:0]  rx_shift;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 rd_addr_received;
    logic [MEM_WIDTH-2:0] tx_shift;
    logic [TX_W-1:0]      tx_cnt;
    logic                 tx_active;
    logic                 tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!SS_n) begin
                    state_nxt = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    state_nxt = IDLE;
                end else if (!MOSI) begin
                    state_nxt = WRITE;
                end else if (rd_addr_received) begin
                    state_nxt = READ_DATA;
                end else begin
                    state_nxt = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MISO             <= 1'b0;
            rx_data          <= '0;
            rx_valid         <= 1'b0;
            rx_shift         <= '0;
            bit_cnt          <= '0;
            rd_addr_received <= 1'b0;
            tx_shift         <= '0;
            tx_cnt           <= '0;
            tx_active        <= 1'b0;
            tx_done          <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            // SS_n high wins over everything, including the 10th-bit strobe
            if (state == IDLE || SS_n) begin
                MISO      <= 1'b0;
                rx_shift  <= '0;
                bit_cnt   <= '0;
                tx_cnt    <= '0;
                tx_active <= 1'b0;
                tx_done   <= 1'b0;
            end else if (state != CHK_CMD) begin
                if (bit_cnt != RX_BITS) begin
                    rx_shift <= {rx_shift[RX_WIDTH-3:0], MOSI};
                    bit_cnt  <= bit_cnt + BIT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        rx_data  <= {rx_shift, MOSI};
                        rx_valid <= 1'b1;
                        if (state == READ_ADD) begin
                            rd_addr_received <= 1'b1;
                        end
                    end
                end else if (state == READ_DATA) begin
                    // Read response: capture, shift MSB-first, then park MISO low until SS_n rises
                    if (tx_active) begin
                        if (tx_cnt != '0) begin
                            MISO     <= tx_shift[MEM_WIDTH-2];
                            tx_shift <= {tx_shift[MEM_WIDTH-3:0], 1'b0};
                            tx_cnt   <= tx_cnt - TX_W'(1);
                        end else begin
                            MISO             <= 1'b0;
                            rd_addr_received <= 1'b0;
                            tx_active        <= 1'b0;
                            tx_done          <= 1'b1;
                        end
                    end else if (!tx_done && tx_valid) begin
                        MISO      <= tx_data[MEM_WIDTH-1];
                        tx_shift  <= tx_data[MEM_WIDTH-2:0];
                        tx_cnt    <= TX_W'(MEM_WIDTH - 1);
                        tx_active <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: table of frames with a queue of expected RAM words, plus read and reset sequences.
module tb_spi_slave_ctrl;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q[$];
    logic [9:0] mon_exp;
    logic       miso_quiet;
    logic [7:0] rd_word;

    typedef struct {
        logic       route;
        logic [9:0] word;
        int         nbits;
        int         extra;
        logic       txp;
        logic       flag;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    spi_slave_ctrl #(.MEM_WIDTH(8), .RX_WIDTH(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every strobe must match the oldest queued word; MISO must be idle when not reading
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(rx_data), 32'hFFFF_FFFF);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(mon_exp));
                end
            end
            if (miso_quiet) begin
                chk("miso_idle", 32'(MISO), 32'd0);
            end
        end
    end

    task automatic start_frame(input logic route, input logic [9:0] word, input int nbits, input logic txp);
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
        @(negedge clk);
        MOSI = route;
        if (nbits == 10) exp_q.push_back(word);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            MOSI     = word[9-i];
            tx_valid = txp && (i == 3);
            tx_data  = 8'hFF;
        end
    endtask

    initial begin
        SS_n       = 1'b1;
        MOSI       = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        rst_n      = 1'b1;
        miso_quiet = 1'b0;
        rd_word    = 8'hA5;

        vecs[0] = '{1'b0, 10'h005, 10, 0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 10'h1A5, 10, 3, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 10'h2C3,  6, 0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 10'h0FF, 10, 0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 10'h155,  9, 0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 10'h205, 10, 0, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 10'h1F0,  4, 0, 1'b0, 1'b1};

        #1 rst_n = 1'b0;
        #2;
        chk("reset_miso", 32'(MISO), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_flag", 32'(dut.rd_addr_received), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        miso_quiet = 1'b1;

        for (int k = 0; k < NV; k++) begin
            start_frame(vecs[k].route, vecs[k].word, vecs[k].nbits, vecs[k].txp);
            @(negedge clk);
            tx_valid = 1'b0;
            chk("strobe_at_10th", 32'(rx_valid), 32'(vecs[k].nbits == 10));
            for (int e = 0; e < vecs[k].extra; e++) begin
                MOSI = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("no_second_strobe", 32'(rx_valid), 32'd0);
            end
            SS_n = 1'b1;
            MOSI = 1'b0;
            @(negedge clk);
            chk("strobe_one_cycle", 32'(rx_valid), 32'd0);
            chk("rd_addr_flag", 32'(dut.rd_addr_received), 32'(vecs[k].flag));
        end

        // Read data frame: RAM answers one cycle after the strobe
        start_frame(1'b1, 10'h3C7, 10, 1'b0);
        @(negedge clk);
        chk("read_strobe", 32'(rx_valid), 32'd1);
        @(negedge clk);
        miso_quiet = 1'b0;
        tx_valid   = 1'b1;
        tx_data    = rd_word;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        chk("miso_bit7", 32'(MISO), 32'(rd_word[7]));
        for (int b = 6; b >= 0; b--) begin
            @(negedge clk);
            chk("miso_bit", 32'(MISO), 32'(rd_word[b]));
        end
        @(negedge clk);
        chk("miso_after_bit0", 32'(MISO), 32'd0);
        chk("flag_cleared", 32'(dut.rd_addr_received), 32'd0);
        miso_quiet = 1'b1;
        MOSI       = 1'b1;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);

        // Read request with no stored address goes down the address path
        start_frame(1'b1, 10'h3AA, 10, 1'b0);
        @(negedge clk);
        chk("noaddr_strobe", 32'(rx_valid), 32'd1);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk("noaddr_miso", 32'(MISO), 32'd0);
        end
        SS_n = 1'b1;
        @(negedge clk);
        chk("noaddr_flag_set", 32'(dut.rd_addr_received), 32'd1);

        // Asynchronous reset in the middle of a write frame
        start_frame(1'b0, 10'h1A5, 5, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_rx_data", 32'(rx_data), 32'd0);
        chk("arst_rx_valid", 32'(rx_valid), 32'd0);
        chk("arst_miso", 32'(MISO), 32'd0);
        chk("arst_flag", 32'(dut.rd_addr_received), 32'd0);
        SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start_frame(1'b0, 10'h005, 10, 1'b0);
        @(negedge clk);
        chk("post_reset_strobe", 32'(rx_valid), 32'd1);
        chk("post_reset_data", 32'(rx_data), 32'h005);
        SS_n = 1'b1;
        @(negedge clk);
        chk("post_reset_one_cycle", 32'(rx_valid), 32'd0);
        @(negedge clk);
        chk("all_strobes_seen", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
